// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//
// Shares one downstream APB bus between two independent APB requesters
// (m0, m1). Exactly one complete transfer is in flight downstream at any
// time. Ownership is decided by round-robin arbitration. The winning
// master's SETUP/ACCESS phases are re-issued downstream, and the slave
// response is routed back only to that master. A watchdog force-completes
// an ACCESS phase whose slave never raises PREADY. The forced completion is
// signalled as an error to the master.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   mN_psel/penable     master request (N = 0, 1); penable is not needed
//   mN_pwrite/paddr/    because the arbiter re-times the phases itself
//   mN_pwdata           master transfer attributes
//   mN_prdata/pready/   response routed back to the granted master only
//   mN_pslverr
//   s_psel/penable/     downstream APB request
//   s_pwrite/paddr/
//   s_pwdata
//   s_prdata/pready/    downstream APB response
//   s_pslverr
//   grant_o             one-hot current owner, 00 while idle
//   timeout_o           one-cycle pulse when the watchdog ends a transfer
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      m0_psel,
  input  logic                      m0_penable,
  input  logic                      m0_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] m0_paddr,
  input  logic [APB_DATA_WIDTH-1:0] m0_pwdata,
  output logic [APB_DATA_WIDTH-1:0] m0_prdata,
  output logic                      m0_pready,
  output logic                      m0_pslverr,

  input  logic                      m1_psel,
  input  logic                      m1_penable,
  input  logic                      m1_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] m1_paddr,
  input  logic [APB_DATA_WIDTH-1:0] m1_pwdata,
  output logic [APB_DATA_WIDTH-1:0] m1_prdata,
  output logic                      m1_pready,
  output logic                      m1_pslverr,

  output logic                      s_psel,
  output logic                      s_penable,
  output logic                      s_pwrite,
  output logic [APB_ADDR_WIDTH-1:0] s_paddr,
  output logic [APB_DATA_WIDTH-1:0] s_pwdata,
  input  logic [APB_DATA_WIDTH-1:0] s_prdata,
  input  logic                      s_pready,
  input  logic                      s_pslverr,

  output logic [1:0]                grant_o,
  output logic                      timeout_o
);

  // When TIMEOUT_CYCLES is 0, the watchdog is disabled. The counter then
  // keeps a 1-bit width so that it never becomes a zero-width vector.
  localparam bit WdEnable = (TIMEOUT_CYCLES > 0);
  localparam int CntWidth = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter holds 0 during the first ACCESS cycle. The TIMEOUT_CYCLES-th
  // stalled cycle is therefore the cycle that sees TIMEOUT_CYCLES-1.
  localparam logic [CntWidth-1:0] LastCount =
    (TIMEOUT_CYCLES > 0) ? CntWidth'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                lastGrant_q, lastGrant_d;
  logic [CntWidth-1:0] wdCount_q, wdCount_d;

  logic                wdExpire;
  logic                xferDone;
  logic                unusedPenable;

  // The arbiter generates its own SETUP/ACCESS phasing downstream, so the
  // masters' penable inputs carry no information that is needed here.
  assign unusedPenable = m0_penable ^ m1_penable;

  // The watchdog fires in the last allowed stalled ACCESS cycle.
  // A slave that becomes ready in that same cycle still wins, because the
  // watchdog only counts cycles without s_pready.
  always_comb begin
    wdExpire = 1'b0;
    if (WdEnable && (state_q == ACCESS) && !s_pready && (wdCount_q == LastCount)) begin
      wdExpire = 1'b1;
    end
  end

  assign xferDone  = (state_q == ACCESS) && (s_pready || wdExpire);
  assign timeout_o = wdExpire;
  assign grant_o   = grant_q;

  // State, ownership and watchdog registers. Reset puts the FSM in IDLE.
  // It also points last grant at m1, so that m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      lastGrant_q <= 1'b1;
      wdCount_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      wdCount_q   <= wdCount_d;
    end
  end

  // Next-state logic. In IDLE, arbitration picks the lone requester, or
  // on a tie picks the master that did not own the previous transfer.
  // SETUP always lasts one cycle. ACCESS holds until the slave answers or
  // the watchdog gives up. Every completion records the owner for the next
  // round-robin decision and returns the bus to IDLE. A requester that keeps
  // psel high is therefore re-arbitrated fresh.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    wdCount_d   = wdCount_q;

    unique case (state_q)
      IDLE: begin
        wdCount_d = '0;
        if (m0_psel && m1_psel) begin
          grant_d = lastGrant_q ? 2'b01 : 2'b10;
          state_d = SETUP;
        end else if (m0_psel) begin
          grant_d = 2'b01;
          state_d = SETUP;
        end else if (m1_psel) begin
          grant_d = 2'b10;
          state_d = SETUP;
        end
      end

      SETUP: begin
        wdCount_d = '0;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (xferDone) begin
          lastGrant_d = grant_q[1];
          grant_d     = 2'b00;
          wdCount_d   = '0;
          state_d     = IDLE;
        end else begin
          wdCount_d = wdCount_q + CntWidth'(1);
        end
      end

      default: begin
        grant_d   = 2'b00;
        wdCount_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Downstream request path. The owner's attributes are passed straight
  // through for the whole transfer, and the bus is all zeros while idle.
  always_comb begin
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    if (state_q != IDLE) begin
      s_psel    = 1'b1;
      s_penable = (state_q == ACCESS);
      if (grant_q[1]) begin
        s_pwrite = m1_pwrite;
        s_paddr  = m1_paddr;
        s_pwdata = m1_pwdata;
      end else begin
        s_pwrite = m0_pwrite;
        s_paddr  = m0_paddr;
        s_pwdata = m0_pwdata;
      end
    end
  end

  // Response path back to the masters. Only the owner sees anything, and
  // only during ACCESS. If the owner has dropped psel mid-transfer, the
  // downstream transfer still finishes but its response is discarded.
  // A watchdog completion reports an error with zero read data.
  always_comb begin
    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m0_prdata  = '0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;
    m1_prdata  = '0;
    if (state_q == ACCESS) begin
      if (grant_q[0] && m0_psel) begin
        m0_pready  = xferDone;
        m0_pslverr = wdExpire | s_pslverr;
        m0_prdata  = wdExpire ? '0 : s_prdata;
      end
      if (grant_q[1] && m1_psel) begin
        m1_pready  = xferDone;
        m1_pslverr = wdExpire | s_pslverr;
        m1_prdata  = wdExpire ? '0 : s_prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Self-checking bench for apb_master_arbiter with TIMEOUT_CYCLES = 16.
// A transaction-level reference model tracks the current owner and the age
// of its transfer (0 = setup, k = k-th access cycle). From that model the
// bench predicts every DUT output on every cycle. Directed scenarios are
// followed by a randomized phase with two masters and a slave.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int VW = 138;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
  logic [AW-1:0] m0_paddr = '0;
  logic [DW-1:0] m0_pwdata = '0;
  logic [DW-1:0] m0_prdata;
  logic          m0_pready, m0_pslverr;
  logic          m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
  logic [AW-1:0] m1_paddr = '0;
  logic [DW-1:0] m1_pwdata = '0;
  logic [DW-1:0] m1_prdata;
  logic          m1_pready, m1_pslverr;
  logic          s_psel, s_penable, s_pwrite;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata;
  logic [DW-1:0] s_prdata = '0;
  logic          s_pready = 1'b0, s_pslverr = 1'b0;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner index (-1 = bus free), transfer age,
  // and the owner of the most recently completed transfer.
  int mOwner = -1;
  int mAge   = 0;
  int mLast  = 1;
  bit expPready0 = 1'b0;
  bit expPready1 = 1'b0;

  apb_master_arbiter #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
    .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
    .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial forever #5 clk = ~clk;

  // Compares one observed value with one expected value.
  // Every check is counted, and any mismatch is reported.
  task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                             input logic [VW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives a request from one master and holds it until it is released.
  task automatic applyStimulus(input int master, input logic write,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (master == 0) begin
      m0_psel = 1'b1; m0_penable = 1'b1; m0_pwrite = write; m0_paddr = addr; m0_pwdata = data;
    end else begin
      m1_psel = 1'b1; m1_penable = 1'b1; m1_pwrite = write; m1_paddr = addr; m1_pwdata = data;
    end
  endtask

  task automatic releaseMaster(input int master);
    if (master == 0) begin
      m0_psel = 1'b0; m0_penable = 1'b0;
    end else begin
      m1_psel = 1'b0; m1_penable = 1'b0;
    end
  endtask

  // Advances n clock cycles and leaves the caller just after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [VW-1:0] dutOutputs();
    return {s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
            m0_pready, m0_pslverr, m0_prdata,
            m1_pready, m1_pslverr, m1_prdata, grant_o, timeout_o};
  endfunction

  // The watchdog ends a transfer in its TO-th access cycle when the slave is
  // still stalling. A transfer completes in any access cycle with pready,
  // or on that watchdog cycle.
  function automatic bit modelWatchdog();
    return (TO > 0) && (mOwner >= 0) && (mAge == TO) && !s_pready;
  endfunction

  function automatic bit modelDone();
    return (mOwner >= 0) && (mAge >= 1) && (s_pready || modelWatchdog());
  endfunction

  function automatic logic [VW-1:0] modelOutputs();
    logic          sp, se, sw, r0, e0, r1, e1, to;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd, d0, d1;
    logic [1:0]    g;
    sp = 1'b0; se = 1'b0; sw = 1'b0; sa = '0; sd = '0;
    r0 = 1'b0; e0 = 1'b0; d0 = '0; r1 = 1'b0; e1 = 1'b0; d1 = '0;
    g = 2'b00; to = 1'b0;
    if (mOwner >= 0) begin
      sp = 1'b1;
      se = (mAge >= 1);
      g  = (mOwner == 0) ? 2'b01 : 2'b10;
      sw = (mOwner == 0) ? m0_pwrite : m1_pwrite;
      sa = (mOwner == 0) ? m0_paddr  : m1_paddr;
      sd = (mOwner == 0) ? m0_pwdata : m1_pwdata;
      if (mAge >= 1) begin
        to = modelWatchdog();
        if (mOwner == 0 && m0_psel) begin
          r0 = modelDone(); e0 = to ? 1'b1 : s_pslverr; d0 = to ? '0 : s_prdata;
        end
        if (mOwner == 1 && m1_psel) begin
          r1 = modelDone(); e1 = to ? 1'b1 : s_pslverr; d1 = to ? '0 : s_prdata;
        end
      end
    end
    return {sp, se, sw, sa, sd, r0, e0, d0, r1, e1, d1, g, to};
  endfunction

  // Reference model state update. It uses the same inputs that the DUT
  // samples on this edge. Reset clears the model immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner <= -1;
      mAge   <= 0;
      mLast  <= 1;
    end else if (mOwner < 0) begin
      if (m0_psel && m1_psel) mOwner <= (mLast == 1) ? 0 : 1;
      else if (m0_psel)       mOwner <= 0;
      else if (m1_psel)       mOwner <= 1;
      mAge <= 0;
    end else if (modelDone()) begin
      mLast  <= mOwner;
      mOwner <= -1;
      mAge   <= 0;
    end else begin
      mAge <= mAge + 1;
    end
  end

  // Per-cycle scoreboard. On every falling edge, the full output vector is
  // compared with the model's prediction.
  initial forever begin
    @(negedge clk);
    expPready0 = (mOwner == 0) && m0_psel && modelDone();
    expPready1 = (mOwner == 1) && m1_psel && modelDone();
    checkOutput("cycle", dutOutputs(), modelOutputs());
  end

  initial begin
    logic [1:0] gotGrant [4];
    logic [1:0] wantGrant [4];
    logic       early;
    int         pulses;
    int         stall;
    wantGrant = '{2'b01, 2'b10, 2'b01, 2'b10};

    // Reset state
    tick(2);
    @(negedge clk);
    checkOutput("reset", dutOutputs(), '0);
    tick(1);
    rst_n = 1'b1;

    // m0 write with a zero-wait slave
    tick(1);
    s_pready = 1'b1;
    applyStimulus(0, 1'b1, 32'h1A10_2000, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t1_idle", VW'(s_psel), VW'(1'b0));
    tick(1);
    @(negedge clk);
    checkOutput("t1_setup", VW'({s_psel, s_penable}), VW'(2'b10));
    tick(1);
    @(negedge clk);
    checkOutput("t1_access", VW'({s_psel, s_penable, s_pwrite}), VW'(3'b111));
    checkOutput("t1_paddr", VW'(s_paddr), VW'(32'h1A10_2000));
    checkOutput("t1_pwdata", VW'(s_pwdata), VW'(32'hDEADBEEF));
    checkOutput("t1_pready", VW'(m0_pready), VW'(1'b1));
    checkOutput("t1_m1quiet", VW'({m1_pready, m1_pslverr, m1_prdata}), '0);
    tick(1);
    releaseMaster(0);
    tick(2);

    // Round-robin order after a fresh reset, with both masters requesting
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    applyStimulus(0, 1'b1, 32'h0000_1000, 32'h1111_1111);
    applyStimulus(1, 1'b0, 32'h0000_2000, 32'h2222_2222);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      @(negedge clk);
      gotGrant[k] = grant_o;
      tick(2);
    end
    releaseMaster(0);
    releaseMaster(1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_grant%0d", k), VW'(gotGrant[k]), VW'(wantGrant[k]));
    end
    tick(2);

    // m1 read with five wait states
    tick(1);
    s_pready = 1'b0;
    s_prdata = 32'hAAAA_5555;
    applyStimulus(1, 1'b0, 32'h0000_0040, '0);
    early = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      @(negedge clk);
      early = early | m1_pready;
    end
    checkOutput("t3_noEarly", VW'(early), VW'(1'b0));
    tick(1);
    s_pready = 1'b1;
    s_prdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("t3_pready", VW'(m1_pready), VW'(1'b1));
    checkOutput("t3_prdata", VW'(m1_prdata), VW'(32'h1234_5678));
    tick(1);
    releaseMaster(1);
    tick(2);

    // Watchdog ends an m0 transfer when the slave never becomes ready
    tick(1);
    s_pready = 1'b0;
    s_prdata = 32'hFFFF_FFFF;
    applyStimulus(0, 1'b0, 32'h0000_0080, '0);
    pulses = 0;
    early  = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick(1);
      @(negedge clk);
      if (timeout_o) pulses++;
      if (c < 17) early = early | m0_pready;
      if (c == 17) begin
        checkOutput("t4_readyErr", VW'({m0_pready, m0_pslverr}), VW'(2'b11));
        checkOutput("t4_prdata", VW'(m0_prdata), '0);
      end
    end
    checkOutput("t4_noEarly", VW'(early), VW'(1'b0));
    tick(1);
    releaseMaster(0);
    @(negedge clk);
    if (timeout_o) pulses++;
    checkOutput("t4_idle", VW'(s_psel), VW'(1'b0));
    checkOutput("t4_pulses", VW'(pulses), VW'(1));
    tick(2);

    // Slave error on an m1 write
    tick(1);
    s_pready  = 1'b1;
    s_pslverr = 1'b1;
    applyStimulus(1, 1'b1, 32'h0000_00C0, 32'hCAFE_F00D);
    tick(2);
    @(negedge clk);
    checkOutput("t5_err", VW'({m1_pready, m1_pslverr, timeout_o}), VW'(3'b110));
    tick(1);
    releaseMaster(1);
    @(negedge clk);
    checkOutput("t5_errGone", VW'(m1_pslverr), VW'(1'b0));
    s_pslverr = 1'b0;
    tick(2);

    // Reset during ACCESS of an m1 transfer, then both masters request
    tick(1);
    s_pready = 1'b0;
    applyStimulus(1, 1'b0, 32'h0000_0100, '0);
    tick(3);
    rst_n = 1'b0;
    applyStimulus(0, 1'b1, 32'h0000_0200, 32'h5A5A_5A5A);
    @(negedge clk);
    checkOutput("t6_reset", dutOutputs(), '0);
    tick(1);
    @(negedge clk);
    checkOutput("t6_resetHeld", dutOutputs(), '0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    @(negedge clk);
    checkOutput("t6_firstGrant", VW'(grant_o), VW'(2'b01));
    releaseMaster(0);
    releaseMaster(1);
    s_pready = 1'b1;
    tick(6);

    // Randomized traffic from both masters against a slave that
    // sometimes stalls for long stretches
    stall = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick(1);
      for (int m = 0; m < 2; m++) begin
        bit active, done;
        active = (m == 0) ? m0_psel : m1_psel;
        done   = (m == 0) ? expPready0 : expPready1;
        if (active && done) begin
          if ($urandom_range(1, 0) == 1)
            applyStimulus(m, ($urandom_range(1, 0) == 1), $urandom, $urandom);
          else
            releaseMaster(m);
        end else if (active && $urandom_range(63, 0) == 0) begin
          releaseMaster(m);
        end else if (!active && $urandom_range(2, 0) == 0) begin
          applyStimulus(m, ($urandom_range(1, 0) == 1), $urandom, $urandom);
        end
      end
      if (stall > 0) begin
        stall--;
        s_pready = 1'b0;
      end else begin
        if ($urandom_range(49, 0) == 0) stall = 20;
        s_pready = ($urandom_range(1, 0) == 1);
      end
      s_pslverr = s_pready && ($urandom_range(3, 0) == 0);
      s_prdata  = $urandom;
    end
    releaseMaster(0);
    releaseMaster(1);
    tick(TO + 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-master APB arbiter that shares the single APB bus into the peripheral bus decoder between two independent APB requesters, for example the AXI2APB bridge and a second configuration master. It grants one complete APB transfer at a time using round-robin arbitration. It re-issues each granted transfer downstream with correct SETUP/ACCESS phasing and returns the slave response only to the granted master. A watchdog terminates transfers whose slave never asserts PREADY.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32, address width of all ports
- APB_DATA_WIDTH, 32, data width of all ports
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before forced error completion; 0 disables the watchdog

Ports (mN = m0, m1, one identical set each):
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- mN_psel  in  1  master select
- mN_penable  in  1  master enable
- mN_pwrite  in  1  master write
- mN_paddr  in  APB_ADDR_WIDTH  master address
- mN_pwdata  in  APB_DATA_WIDTH  master write data
- mN_prdata  out  APB_DATA_WIDTH  read data returned to master
- mN_pready  out  1  transfer complete to master
- mN_pslverr  out  1  error to master
- s_psel, s_penable, s_pwrite  out  1  downstream APB control
- s_paddr  out  APB_ADDR_WIDTH  downstream address
- s_pwdata  out  APB_DATA_WIDTH  downstream write data
- s_prdata  in  APB_DATA_WIDTH  downstream read data
- s_pready, s_pslverr  in  1  downstream response
- grant_o  out  2  one-hot current owner; 00 in IDLE
- timeout_o  out  1  single-cycle pulse on watchdog completion

## Operation
- FSM with three states: IDLE, SETUP, ACCESS.
- IDLE: a request is mN_psel=1. With a single requester, that master wins. With both requesting, the master not in last_grant wins. last_grant resets to 1, so m0 wins first. On a win, load the grant register and go to SETUP.
- SETUP: s_psel=1, s_penable=0, lasting one cycle, then go to ACCESS.
- ACCESS: s_psel=1, s_penable=1. Completion occurs on s_pready=1 or on the watchdog. On completion: set last_grant to the granted master, clear grant, and go to IDLE.
- s_pwrite, s_paddr and s_pwdata are combinationally muxed from the granted master in SETUP/ACCESS. All s_* outputs are 0 in IDLE.
- Response path is combinational in ACCESS. For the granted master: mN_pready=s_pready, mN_prdata=s_prdata, mN_pslverr=s_pslverr. The non-granted master sees pready=0, prdata=0, pslverr=0 at all times.
- Watchdog: a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with s_pready=0. In the TIMEOUT_CYCLES-th such cycle: mN_pready=1, mN_pslverr=1, mN_prdata=0, timeout_o=1, then go to IDLE. s_pready=1 in that same cycle takes priority and produces a normal completion.
- Master drops psel during SETUP/ACCESS (protocol violation): the downstream transfer runs to completion and the response is discarded. No pready is returned to that master.
- A master may keep psel high across the IDLE gap. It is re-arbitrated as a new request.

## Timing
- Reset values: all s_* outputs, all mN_* outputs, grant_o and timeout_o are 0. FSM=IDLE, last_grant=1, counter=0.
- Reset assertion mid-transfer forces the reset values immediately (asynchronous). The interrupted transfer is dropped with no response.
- Latency, zero-wait slave: master psel at cycle t, s_psel at t+1, s_penable at t+2, mN_pready at t+2. The master sees one extra wait cycle versus direct connection.
- Wait states: mN_pready is asserted in the same cycle as s_pready.
- Back-to-back: completion at t, IDLE at t+1, next SETUP at t+2. Minimum 3 cycles per transfer.
- Only one transfer is ever outstanding downstream. grant_o changes only on the IDLE→SETUP and ACCESS→IDLE transitions.

## Test plan
- m0 write, paddr=0x1A10_2000, pwdata=0xDEADBEEF, slave pready=1 immediately -> s_psel rises at t+1, s_penable at t+2 with s_paddr/s_pwdata matching, m0_pready=1 at t+2, m1 outputs 0 throughout.
- m0 and m1 request in the same cycle after reset, both re-requesting continuously for 4 transfers -> grant order m0, m1, m0, m1; grant_o 01, 10, 01, 10.
- m1 read, slave holds pready=0 for 5 ACCESS cycles then returns s_prdata=0x1234_5678 -> m1_pready=1 with m1_prdata=0x1234_5678 at t+7; no earlier pready.
- TIMEOUT_CYCLES=16, slave never ready -> in the 16th ACCESS cycle m0_pready=1, m0_pslverr=1, m0_prdata=0, timeout_o pulses once; s_psel=0 in the next cycle.
- Slave returns pslverr=1 with pready=1 on an m1 write -> m1_pslverr=1 for exactly that cycle; timeout_o stays 0.
- rst_n asserted during ACCESS of an m1 transfer, then released with both masters requesting -> all outputs 0 during reset; first grant after release is m0.
